seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Output-side counterpart of the keypad scanner: time-multiplexes a 4-digit BCD value onto the shared 7-segment bus and the DS1..DS4 digit-select lines.
- Sits between the calculator FSM/ALU result path and the display pins.
- Provides tear-free value updates, anti-ghosting blanking gaps, leading-zero suppression, per-digit decimal points and a minus glyph.
- Runs from the low-frequency internal oscillator clock.

Parameters:
- DIGIT_TICKS, 25: clk cycles per digit slot (10 kHz clk gives 400 Hz/digit, 100 Hz frame); legal range 4..255.
- GAP_TICKS, 2: cycles at the start of each slot with all selects inactive; must be < DIGIT_TICKS.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp outputs.
- SEL_ACTIVE_LOW, 0: 1 inverts digit_sel outputs.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enabled; low forces display dark.
- value  in  16  4 BCD nibbles; [3:0] is digit 0 (rightmost, DS4), [15:12] is digit 3 (DS1).
- dp_mask  in  4  decimal point per digit, bit i for digit i.
- blank_lz  in  1  enable leading-zero blanking.
- load  in  1  one-cycle strobe; capture value/dp_mask/blank_lz.
- seg  out  7  segments a..g, bit0 = a.
- dp  out  1  decimal point segment.
- digit_sel  out  4  one-hot digit enable, bit i = digit i.
- frame_start  out  1  one-cycle pulse at start of digit-0 slot.
- pending  out  1  a loaded value awaits transfer to the active register.

Behaviour:
Registers:
- pend_reg: holds value, dp_mask and blank_lz (21 bits).
- act_reg: same width as pend_reg.
- pending flag, tick counter (8 bits), digit index (2 bits), state.

Reset (async, resetn=0):
- seg, dp and digit_sel inactive (polarity per parameters); frame_start=0; pending=0.
- act_reg=0, pend_reg=0, counters=0, state=IDLE.

Load handshake:
- load=1 writes pend_reg and sets pending on the same edge.
- A load while pending=1 overwrites pend_reg (last write wins); no stall, no ack.

States:
- IDLE: outputs inactive. Leaves when enable=1 → GAP with digit=0, tick=0; this cycle is a frame boundary.
- GAP: digit_sel inactive, seg/dp inactive. After GAP_TICKS cycles → ON.
- ON: digit_sel[digit] active; seg/dp driven from act_reg nibble for digit.
  - When tick reaches DIGIT_TICKS-1: tick=0, digit=digit+1 (wraps 3→0), → GAP.
  - The wrap to 0 is a frame boundary.
- Any state with enable=0 → IDLE on the next edge; digit index cleared. act_reg and pend_reg are retained.

Frame boundary:
- frame_start=1 for exactly the first GAP cycle of digit 0.
- If pending=1: act_reg<=pend_reg, pending cleared.
- If load coincides with the boundary: act_reg<=live inputs directly, and pending stays 0.
- act_reg never changes mid-frame.

Glyph decode (nibble → segments a..g):
- 0..9: standard digits.
- 0xA: minus (g only).
- 0xB..0xF: blank.

Leading-zero blanking:
- With blank_lz=1, digit i (i=3..1) is blank if its nibble is 0 and all higher digits are 0 or blank.
- Digit 0 always shows.
- dp on a blanked digit still follows dp_mask.

Latency and period:
- Load to visible: at most one frame plus one slot.
- Slot = DIGIT_TICKS cycles; frame = 4*DIGIT_TICKS.
- At most one digit_sel bit is ever active.

Decomposition:
- Shared package: glyph constants (SEG_BLANK, SEG_MINUS, digit table), state encoding, MINUS_CODE=4'hA.
- One sub-module: seg7_decode (combinational nibble → 7-bit glyph), reusable by other display paths.

Test Plan:
All scenarios use DIGIT_TICKS=8, GAP_TICKS=2, active-high polarity.
1. Reset release with enable=1, no load → frame_start pulses every 32 cycles; digit 0 shows 0x3F (glyph 0), digits 1..3 show 0x3F; digit_sel sequence 0001, 0010, 0100, 1000; each select high 6 cycles then 2 gap cycles.
2. Load value=16'h1234, dp_mask=4'b0100 mid-frame → current frame unchanged; next frame digit 3=0x06, 2=0x5B with dp=1, 1=0x4F, 0=0x66; pending 1→0 at frame_start.
3. blank_lz=1, value=16'h0070 → digits 3 and 2 blank (seg=0), digit 1=0x07, digit 0=0x3F; repeat with 16'h0000 → only digit 0 lit (0x3F).
4. value=16'hA005, blank_lz=1 → digit 3=0x40 (minus), digits 2 and 1=0x3F (not blanked, minus is non-zero), digit 0=0x6D.
5. Two loads (16'h1111 then 16'h2222) in one frame, plus a third load on the frame_start cycle (16'h3333) → next frame shows 3333, pending=0.
6. enable dropped during ON of digit 2 → next edge digit_sel=0 and seg=0. Re-enable → frame_start on the first cycle, starting at digit 0. Assert resetn=0 mid-slot → outputs inactive immediately (asynchronous), act_reg=0.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver_pkg : glyph table, scan states and display word layout
// Rev 1.0
// ============================================================================
package seg7_scan_driver_pkg;

    localparam logic [3:0] MINUS_CODE = 4'hA;
    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam logic [6:0] SEG_MINUS  = 7'h40;

    // Segment patterns for 0..9, bit0 = a; index 9 is the leftmost entry.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_ON   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_mask;
        logic        blank_lz;
    } disp_word_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : combinational nibble to 7-segment glyph (0-9, minus, blank)
// Rev 1.0
// ============================================================================
module seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (nibble_i <= 4'd9) begin
            seg_o = SEG_DIGITS[nibble_i];
        end else if (nibble_i == MINUS_CODE) begin
            seg_o = SEG_MINUS;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : 4-digit multiplexed 7-segment scanner with tear-free load
// Rev 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGIT_TICKS    = 25,
    parameter int GAP_TICKS      = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic        frame_start,
    output logic        pending
);

    localparam logic [7:0] SLOT_LAST = 8'(DIGIT_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

    scan_state_e state_q, state_d;
    logic [7:0]  tick_q, tick_d;
    logic [1:0]  digit_q, digit_d;
    disp_word_t  pend_q, pend_d;
    disp_word_t  act_q, act_d;
    logic        pending_q, pending_d;

    disp_word_t  in_word;
    logic        boundary;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_glyph;
    logic        lz3, lz2, lz1;
    logic [3:0]  lz_vec;
    logic [6:0]  seg_raw;
    logic        dp_raw;
    logic [3:0]  sel_raw;

    assign in_word  = '{value: value, dp_mask: dp_mask, blank_lz: blank_lz};
    assign boundary = (state_q == ST_GAP) && (digit_q == 2'd0) && (tick_q == 8'd0);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        digit_d = digit_q;
        if (!enable) begin
            state_d = ST_IDLE;
            tick_d  = 8'd0;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GAP;
                    tick_d  = 8'd0;
                    digit_d = 2'd0;
                end
                ST_GAP: begin
                    tick_d = tick_q + 8'd1;
                    if (tick_q == GAP_LAST) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (tick_q == SLOT_LAST) begin
                        tick_d  = 8'd0;
                        digit_d = digit_q + 2'd1;
                        state_d = ST_GAP;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The active word only moves on the first gap cycle of digit 0, so a frame never tears.
    always_comb begin
        pend_d    = pend_q;
        pending_d = pending_q;
        act_d     = act_q;
        if (load) begin
            pend_d    = in_word;
            pending_d = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                act_d     = in_word;
                pending_d = 1'b0;
            end else if (pending_q) begin
                act_d     = pend_q;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            tick_q    <= 8'd0;
            digit_q   <= 2'd0;
            pend_q    <= '0;
            act_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            digit_q   <= digit_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            pending_q <= pending_d;
        end
    end

    // A digit is leading-zero blank only while every digit to its left is blank too.
    assign lz3    = act_q.blank_lz && (act_q.value[15:12] == 4'd0);
    assign lz2    = lz3 && (act_q.value[11:8] == 4'd0);
    assign lz1    = lz2 && (act_q.value[7:4] == 4'd0);
    assign lz_vec = {lz3, lz2, lz1, 1'b0};

    assign cur_nibble = act_q.value[{digit_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (cur_glyph)
    );

    always_comb begin
        seg_raw = SEG_BLANK;
        dp_raw  = 1'b0;
        sel_raw = 4'b0000;
        if (state_q == ST_ON) begin
            sel_raw = 4'b0001 << digit_q;
            seg_raw = lz_vec[digit_q] ? SEG_BLANK : cur_glyph;
            dp_raw  = act_q.dp_mask[digit_q];
        end
    end

    assign seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign dp          = (SEG_ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
    assign digit_sel   = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    assign frame_start = boundary;
    assign pending     = pending_q;

endmodule
`default_nettype wire
